// File: rtl/mem_port_arbiter.sv
// Two-master arbiter for the memory data port: registered grant, burst lock bounded by LOCK_MAX.
// Optional `MEM_ARB_ROUND_ROBIN_EN selects round-robin ties; default is fixed priority (m0 wins).
module mem_port_arbiter #(
   parameter int unsigned ADDR_W   = 16,
   parameter int unsigned DATA_W   = 16,
   parameter int unsigned LOCK_MAX = 8
) (
   input  logic              clk,
   input  logic              reset_i,
   input  logic              m0_req_i,
   input  logic              m0_we_i,
   input  logic              m0_lock_i,
   input  logic [ADDR_W-1:0] m0_addr_i,
   input  logic [DATA_W-1:0] m0_wdata_i,
   output logic              m0_ack_o,
   output logic [DATA_W-1:0] m0_rdata_o,
   input  logic              m1_req_i,
   input  logic              m1_we_i,
   input  logic              m1_lock_i,
   input  logic [ADDR_W-1:0] m1_addr_i,
   input  logic [DATA_W-1:0] m1_wdata_i,
   output logic              m1_ack_o,
   output logic [DATA_W-1:0] m1_rdata_o,
   output logic [ADDR_W-1:0] d_addr_o,
   output logic              d_we_o,
   output logic [DATA_W-1:0] d_data_o,
   input  logic [DATA_W-1:0] d_data_i,
   output logic [1:0]        grant_o
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] GNT0 = 2'd1;
   localparam logic [1:0] GNT1 = 2'd2;

   localparam int unsigned TW = (LOCK_MAX < 2) ? 1 : $clog2(LOCK_MAX + 1);
   localparam logic [TW:0] LIM = (TW + 1)'(LOCK_MAX);

   logic [1:0]    state, state_nxt;
   logic          last_m1, last_nxt;
   logic [TW-1:0] tenure;
   logic [TW:0]   ten_p1;
   logic          acc0, acc1, at_lim;
   logic          hold0, hold1, force0, force1, tie_m1;

   always_comb begin
      // Reset blanks the port immediately so a burst cannot commit a write during reset.
      acc0     = !reset_i && (state == GNT0) && m0_req_i;
      acc1     = !reset_i && (state == GNT1) && m1_req_i;
      last_nxt = acc0 ? 1'b0 : (acc1 ? 1'b1 : last_m1);
      ten_p1   = {1'b0, tenure} + {{TW{1'b0}}, 1'b1};
      at_lim   = (LOCK_MAX != 0) && (ten_p1 >= LIM);
      hold0    = acc0 && m0_lock_i && !at_lim;
      hold1    = acc1 && m1_lock_i && !at_lim;
      // A locked holder that used up its tenure yields to a pending peer.
      force1   = acc0 && m0_lock_i && at_lim;
      force0   = acc1 && m1_lock_i && at_lim;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      tie_m1   = !last_nxt;
`else
      tie_m1   = 1'b0;
`endif
      state_nxt = IDLE;
      if (hold0)
         state_nxt = GNT0;
      else if (hold1)
         state_nxt = GNT1;
      else if (m0_req_i && m1_req_i)
         state_nxt = (force1 || (tie_m1 && !force0)) ? GNT1 : GNT0;
      else if (m0_req_i)
         state_nxt = GNT0;
      else if (m1_req_i)
         state_nxt = GNT1;
   end

   always_ff @(posedge clk) begin
      if (reset_i) begin
         state   <= IDLE;
         last_m1 <= 1'b1;
         tenure  <= '0;
      end else begin
         state   <= state_nxt;
         last_m1 <= last_nxt;
         if (state_nxt == IDLE || state_nxt != state)
            tenure <= '0;
         else if ((acc0 || acc1) && (tenure != {TW{1'b1}}))
            tenure <= ten_p1[TW-1:0];
      end
   end

   always_comb begin
      d_addr_o   = '0;
      d_we_o     = 1'b0;
      d_data_o   = '0;
      m0_rdata_o = '0;
      m1_rdata_o = '0;
      if (acc0) begin
         d_addr_o   = m0_addr_i;
         d_we_o     = m0_we_i;
         d_data_o   = m0_wdata_i;
         m0_rdata_o = d_data_i;
      end else if (acc1) begin
         d_addr_o   = m1_addr_i;
         d_we_o     = m1_we_i;
         d_data_o   = m1_wdata_i;
         m1_rdata_o = d_data_i;
      end
   end

   assign m0_ack_o = acc0;
   assign m1_ack_o = acc1;
   assign grant_o  = reset_i ? 2'b00 : {state == GNT1, state == GNT0};

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus queues expected accesses, a negedge monitor checks them.
module tb_mem_port_arbiter;
   logic        clk     = 1'b0;
   logic        reset_i = 1'b1;
   logic [1:0]  req     = '0;
   logic [1:0]  we      = '0;
   logic [1:0]  lock    = '0;
   logic [1:0]  ack;
   logic [15:0] addr  [2];
   logic [15:0] wdata [2];
   logic [15:0] rdata [2];
   logic [15:0] d_addr, d_wdat, d_rdat;
   logic        d_we;
   logic [1:0]  grant;
   logic [15:0] mem [1024];
   logic        loaded = 1'b0;

   typedef struct packed {
      logic        m;
      logic        we;
      logic [15:0] addr;
      logic [15:0] data;
   } exp_t;

   exp_t sb [$];
   exp_t mon_e;
   int   checks = 0;
   int   passed = 0;
   int   fails  = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .LOCK_MAX(8)) dut (
      .clk(clk), .reset_i(reset_i),
      .m0_req_i(req[0]), .m0_we_i(we[0]), .m0_lock_i(lock[0]), .m0_addr_i(addr[0]),
      .m0_wdata_i(wdata[0]), .m0_ack_o(ack[0]), .m0_rdata_o(rdata[0]),
      .m1_req_i(req[1]), .m1_we_i(we[1]), .m1_lock_i(lock[1]), .m1_addr_i(addr[1]),
      .m1_wdata_i(wdata[1]), .m1_ack_o(ack[1]), .m1_rdata_o(rdata[1]),
      .d_addr_o(d_addr), .d_we_o(d_we), .d_data_o(d_wdat), .d_data_i(d_rdat),
      .grant_o(grant)
   );

   // Memory with combinational read and edge-committed write.
   assign d_rdat = mem[d_addr[9:0]];
   always @(posedge clk) begin
      if (!loaded) begin
         for (int i = 0; i < 1024; i++) mem[i] <= 16'h0000;
         mem[10'h005] <= 16'hBEEF;
         for (int i = 0; i < 16; i++) begin
            mem[10'h020 + 10'(i)] <= 16'h2000 + 16'(i);
            mem[10'h030 + 10'(i)] <= 16'h3000 + 16'(i);
            mem[10'h050 + 10'(i)] <= 16'h5000 + 16'(i);
         end
         loaded <= 1'b1;
      end else if (d_we) begin
         mem[d_addr[9:0]] <= d_wdat;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push(input logic m, input logic w, input logic [15:0] a, input logic [15:0] d);
      exp_t e;
      e.m = m; e.we = w; e.addr = a; e.data = d;
      sb.push_back(e);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Called just after a rising edge; presents n accesses, each held until acked.
   task automatic master_burst(input int m, input int n, input logic w, input logic lk,
                               input logic [15:0] a0, input logic [15:0] d0);
      int waited;
      for (int i = 0; i < n; i++) begin
         req[m] = 1'b1; we[m] = w; lock[m] = lk;
         addr[m] = a0 + 16'(i); wdata[m] = d0 + 16'(i);
         waited = 0;
         do begin
            @(negedge clk);
            waited++;
         end while (!ack[m] && waited < 40);
         chk("ack_wait", 32'(ack[m]), 32'h1);
         @(posedge clk);
         #1;
      end
      req[m] = 1'b0; we[m] = 1'b0; lock[m] = 1'b0;
   endtask

   always @(negedge clk) begin
      if (ack != 2'b00) begin
         if (sb.size() == 0) chk("unexpected_ack", 32'(ack), 32'h0);
         else begin
            mon_e = sb.pop_front();
            chk("ack_owner", 32'(ack), mon_e.m ? 32'h2 : 32'h1);
            chk("acc_addr", 32'(d_addr), 32'(mon_e.addr));
            chk("acc_we", 32'(d_we), 32'(mon_e.we));
            chk("acc_data", mon_e.we ? 32'(d_wdat) : 32'(mon_e.m ? rdata[1] : rdata[0]),
                32'(mon_e.data));
            chk("other_rdata", 32'(mon_e.m ? rdata[0] : rdata[1]), 32'h0);
         end
      end else begin
         chk("idle_port", {15'h0, d_we, d_addr}, 32'h0);
         chk("idle_rdata", {rdata[1], rdata[0]}, 32'h0);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      addr[0] = '0; addr[1] = '0; wdata[0] = '0; wdata[1] = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_grant", 32'(grant), 32'h0);
      chk("rst_ack", 32'(ack), 32'h0);
      @(posedge clk); #1;
      reset_i = 1'b0;

      // Single m0 read: granted and acked one cycle after the request.
      req[0] = 1'b1; we[0] = 1'b0; addr[0] = 16'h0005;
      push(1'b0, 1'b0, 16'h0005, 16'hBEEF);
      @(negedge clk);
      chk("t1_req_grant", 32'(grant), 32'h0);
      chk("t1_req_ack", 32'(ack), 32'h0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("t1_grant", 32'(grant), 32'h1);
      chk("t1_ack", 32'(ack), 32'h1);
      @(posedge clk); #1;
      req[0] = 1'b0;
      @(negedge clk);
      chk("t1_no_dup", 32'(ack), 32'h0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("t1_idle", 32'(grant), 32'h0);
      @(posedge clk); #1;

      // m1 write then m0 read-back.
      push(1'b1, 1'b1, 16'h0010, 16'h1234);
      push(1'b0, 1'b0, 16'h0010, 16'h1234);
      master_burst(1, 1, 1'b1, 1'b0, 16'h0010, 16'h1234);
      master_burst(0, 1, 1'b0, 1'b0, 16'h0010, 16'h0000);
      idle(3);

      // Both masters streaming unlocked reads; last served before this is m0.
`ifdef MEM_ARB_ROUND_ROBIN_EN
      for (int i = 0; i < 4; i++) begin
         push(1'b1, 1'b0, 16'h0030 + 16'(i), 16'h3000 + 16'(i));
         push(1'b0, 1'b0, 16'h0020 + 16'(i), 16'h2000 + 16'(i));
      end
`else
      for (int i = 0; i < 4; i++) push(1'b0, 1'b0, 16'h0020 + 16'(i), 16'h2000 + 16'(i));
      for (int i = 0; i < 4; i++) push(1'b1, 1'b0, 16'h0030 + 16'(i), 16'h3000 + 16'(i));
`endif
      fork
         master_burst(0, 4, 1'b0, 1'b0, 16'h0020, 16'h0000);
         master_burst(1, 4, 1'b0, 1'b0, 16'h0030, 16'h0000);
      join
      idle(3);

      // m1 locked burst of 12 against a pending m0: tenure capped at 8.
      for (int i = 0; i < 8; i++) push(1'b1, 1'b0, 16'h0050 + 16'(i), 16'h5000 + 16'(i));
      push(1'b0, 1'b0, 16'h0024, 16'h2004);
      for (int i = 8; i < 12; i++) push(1'b1, 1'b0, 16'h0050 + 16'(i), 16'h5000 + 16'(i));
      fork
         master_burst(1, 12, 1'b0, 1'b1, 16'h0050, 16'h0000);
         begin
            repeat (2) @(posedge clk);
            #1;
            master_burst(0, 1, 1'b0, 1'b0, 16'h0024, 16'h0000);
         end
      join
      idle(3);

      // Reset lands during the third write of a locked m1 burst.
      push(1'b1, 1'b1, 16'h0040, 16'hC000);
      push(1'b1, 1'b1, 16'h0041, 16'hC001);
      req[1] = 1'b1; we[1] = 1'b1; lock[1] = 1'b1; addr[1] = 16'h0040; wdata[1] = 16'hC000;
      @(posedge clk); #1;
      @(negedge clk);
      chk("t5_ack0", 32'(ack), 32'h2);
      @(posedge clk); #1;
      addr[1] = 16'h0041; wdata[1] = 16'hC001;
      @(negedge clk);
      chk("t5_ack1", 32'(ack), 32'h2);
      @(posedge clk); #1;
      addr[1] = 16'h0042; wdata[1] = 16'hC002; reset_i = 1'b1;
      @(negedge clk);
      chk("t5_rst_we", 32'(d_we), 32'h0);
      chk("t5_rst_ack", 32'(ack), 32'h0);
      @(posedge clk); #1;
      reset_i = 1'b0; req[1] = 1'b0; we[1] = 1'b0; lock[1] = 1'b0;
      @(negedge clk);
      chk("t5_grant", 32'(grant), 32'h0);
      idle(2);
      chk("t5_mem40", 32'(mem[10'h040]), 32'hC000);
      chk("t5_mem41", 32'(mem[10'h041]), 32'hC001);
      chk("t5_mem42", 32'(mem[10'h042]), 32'h0);
      chk("t5_mem43", 32'(mem[10'h043]), 32'h0);

      // m0 write request withdrawn in the granted cycle: no access, then IDLE.
      req[0] = 1'b1; we[0] = 1'b1; addr[0] = 16'h0060; wdata[0] = 16'h7777;
      @(posedge clk); #1;
      req[0] = 1'b0;
      @(negedge clk);
      chk("t6_grant", 32'(grant), 32'h1);
      chk("t6_ack", 32'(ack), 32'h0);
      chk("t6_we", 32'(d_we), 32'h0);
      chk("t6_addr", 32'(d_addr), 32'h0);
      @(posedge clk); #1;
      we[0] = 1'b0;
      @(negedge clk);
      chk("t6_idle", 32'(grant), 32'h0);
      idle(2);
      chk("t6_mem60", 32'(mem[10'h060]), 32'h0);

      chk("sb_drain", 32'(sb.size()), 32'h0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
